// File: rtl/gift_keysched_engine.sv
// GIFT-128 key schedule engine: expands a 128-bit master key into ROUNDS
// 32-bit round keys. It emits LANES keys per beat through a small output FIFO
// with valid/ready handshaking.
module gift_keysched_engine #(
  parameter int ROUNDS = 40,
  parameter int LANES  = 1,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [127:0]          key_in,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [32*LANES-1:0]   rk_data,
  output logic [5:0]            rk_idx,
  output logic                  rk_last,
  output logic                  done
);

  localparam int DW = 32 * LANES;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic          last;
    logic [5:0]    idx;
    logic [DW-1:0] data;
  } beat_t;

  // Rotate a 16-bit half right by n positions.
  function automatic logic [15:0] ror16(input logic [15:0] x, input int n);
    return (x >> n) | (x << (16 - n));
  endfunction

  // Key-word update applied to the word that wraps from K0 to K3.
  function automatic logic [31:0] ku(input logic [31:0] w);
    return {ror16(w[31:16], 2), ror16(w[15:0], 12)};
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   key_q   [4];
  logic [31:0]   key_adv [4];
  logic [5:0]    ctr_q;
  beat_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  beat_t         beat_in, head;
  logic          pop, push, can_accept, last_beat, done_int;

  assign head       = mem[rd_ptr_q];
  assign rk_valid   = (count_q != '0) && !rst;
  assign pop        = rk_valid && rk_ready;
  assign can_accept = (count_q < CW'(DEPTH)) || pop;
  assign push       = (state_q == RUN) && can_accept && !abort;
  assign last_beat  = ({1'b0, ctr_q} + 7'(LANES)) == 7'(ROUNDS);

  assign busy    = (state_q != IDLE) && !rst;
  assign rk_data = rk_valid ? head.data : '0;
  assign rk_idx  = rk_valid ? head.idx  : '0;
  assign rk_last = rk_valid && head.last;
  assign done    = done_int && !rst;

  // Advance the key state by LANES steps. Each word is updated at most once
  // because LANES <= 4.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (i + LANES < 4) key_adv[i] = key_q[2'((i + LANES) % 4)];
      else               key_adv[i] = ku(key_q[2'((i + LANES) % 4)]);
    end
  end

  // Assemble the beat to push: lane j carries the current Kj.
  always_comb begin
    beat_in      = '0;
    beat_in.idx  = ctr_q;
    beat_in.last = last_beat;
    for (int j = 0; j < LANES; j++) beat_in.data[32*j +: 32] = key_q[2'(j)];
  end

  // FSM state register.
  // NOTE: sequential state is always updated with non-blocking assignments,
  // so every flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and the done pulse. Abort overrides every transition.
  always_comb begin
    state_d  = state_q;
    done_int = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (push && last_beat) state_d = DRAIN;
        DRAIN:   if (count_q == '0) begin
                   state_d  = IDLE;
                   done_int = 1'b1;
                 end
        default: state_d = IDLE;
      endcase
    end
  end

  // Key state, round counter and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) key_q[i] <= '0;
      ctr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort) begin
      ctr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        for (int i = 0; i < 4; i++) key_q[i] <= key_in[32*i +: 32];
        ctr_q <= '0;
      end
      if (push) begin
        for (int i = 0; i < 4; i++) key_q[i] <= key_adv[i];
        ctr_q    <= ctr_q + 6'(LANES);
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array is not reset. The count and pointers alone decide
  // validity, and the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= beat_in;
  end

endmodule

// File: tb/tb_gift_keysched_engine.sv
// Self-checking bench for gift_keysched_engine. It uses three instances:
// LANES=1/ROUNDS=40, LANES=4/ROUNDS=8, and LANES=2/ROUNDS=2. Expected beats
// come from an independent key-schedule model and are pushed to scoreboards.
module tb_gift_keysched_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [127:0] a_key;
  logic         a_start, a_abort, a_ready;
  logic         a_busy, a_valid, a_last, a_done;
  logic [31:0]  a_data;
  logic [5:0]   a_idx;

  logic [127:0] b_key;
  logic         b_start, b_abort, b_ready;
  logic         b_busy, b_valid, b_last, b_done;
  logic [127:0] b_data;
  logic [5:0]   b_idx;

  logic [127:0] c_key;
  logic         c_start, c_abort, c_ready;
  logic         c_busy, c_valid, c_last, c_done;
  logic [63:0]  c_data;
  logic [5:0]   c_idx;

  gift_keysched_engine #(.ROUNDS(40), .LANES(1), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .key_in(a_key), .start(a_start), .abort(a_abort),
    .busy(a_busy), .rk_valid(a_valid), .rk_ready(a_ready), .rk_data(a_data),
    .rk_idx(a_idx), .rk_last(a_last), .done(a_done));

  gift_keysched_engine #(.ROUNDS(8), .LANES(4), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .key_in(b_key), .start(b_start), .abort(b_abort),
    .busy(b_busy), .rk_valid(b_valid), .rk_ready(b_ready), .rk_data(b_data),
    .rk_idx(b_idx), .rk_last(b_last), .done(b_done));

  gift_keysched_engine #(.ROUNDS(2), .LANES(2), .DEPTH(2)) dut_c (
    .clk(clk), .rst(rst), .key_in(c_key), .start(c_start), .abort(c_abort),
    .busy(c_busy), .rk_valid(c_valid), .rk_ready(c_ready), .rk_data(c_data),
    .rk_idx(c_idx), .rk_last(c_last), .done(c_done));

  typedef struct {
    logic [127:0] data;
    logic [5:0]   idx;
    logic         last;
  } beat_t;

  beat_t sb_a[$];
  beat_t sb_b[$];
  int    n_checks  = 0;
  int    n_errors  = 0;
  bit    gap_chk   = 1'b0;
  logic  a_done_exp = 1'b0;
  logic  b_done_exp = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference key update, written as explicit bit rearrangement.
  function automatic logic [31:0] ku_m(input logic [31:0] w);
    return {w[17:16], w[31:18], w[11:0], w[15:12]};
  endfunction

  task automatic gen_rks(input logic [127:0] key, output logic [31:0] rk[64]);
    logic [31:0] k[4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) k[i] = key[32*i +: 32];
    for (int r = 0; r < 64; r++) begin
      rk[r] = k[0];
      t = k[0]; k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = ku_m(t);
    end
  endtask

  task automatic start_a(input logic [127:0] key);
    logic [31:0] rk[64];
    gen_rks(key, rk);
    for (int r = 0; r < 40; r++)
      sb_a.push_back('{data: {96'b0, rk[r]}, idx: 6'(r), last: (r == 39)});
    a_key = key; a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
  endtask

  task automatic start_b(input logic [127:0] key);
    logic [31:0] rk[64];
    gen_rks(key, rk);
    for (int b = 0; b < 2; b++)
      sb_b.push_back('{data: {rk[4*b+3], rk[4*b+2], rk[4*b+1], rk[4*b]},
                       idx: 6'(4*b), last: (b == 1)});
    b_key = key; b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
  endtask

  task automatic wait_done_a();
    int n = 0;
    do begin @(negedge clk); n++; end while (!a_done && n < 400);
    check("a_done_seen", a_done, 1'b1);
    check("a_sb_empty", 128'(sb_a.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_done_b();
    int n = 0;
    do begin @(negedge clk); n++; end while (!b_done && n < 100);
    check("b_done_seen", b_done, 1'b1);
    check("b_sb_empty", 128'(sb_b.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor for instance A: head vs expected, pops, done timing.
  always @(negedge clk) begin
    if (rst) begin
      a_done_exp = 1'b0;
    end else begin
      check("a_done", a_done, a_done_exp);
      a_done_exp = 1'b0;
      if (gap_chk && sb_a.size() > 0) check("a_no_gap", a_valid, 1'b1);
      if (a_valid) begin
        if (sb_a.size() == 0) begin
          check("a_unexpected_beat", a_valid, 1'b0);
        end else begin
          check("a_data", a_data, sb_a[0].data);
          check("a_idx", a_idx, sb_a[0].idx);
          check("a_last", a_last, sb_a[0].last);
          if (a_ready) begin
            a_done_exp = sb_a[0].last;
            void'(sb_a.pop_front());
          end
        end
      end
    end
  end

  // Scoreboard monitor for instance B.
  always @(negedge clk) begin
    if (rst) begin
      b_done_exp = 1'b0;
    end else begin
      check("b_done", b_done, b_done_exp);
      b_done_exp = 1'b0;
      if (b_valid) begin
        if (sb_b.size() == 0) begin
          check("b_unexpected_beat", b_valid, 1'b0);
        end else begin
          check("b_data", b_data, sb_b[0].data);
          check("b_idx", b_idx, sb_b[0].idx);
          check("b_last", b_last, sb_b[0].last);
          if (b_ready) begin
            b_done_exp = sb_b[0].last;
            void'(sb_b.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] key;
    int           n;

    rst = 1'b1;
    a_key = '0; a_start = 0; a_abort = 0; a_ready = 0;
    b_key = '0; b_start = 0; b_abort = 0; b_ready = 0;
    c_key = '0; c_start = 0; c_abort = 0; c_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", a_busy, 1'b0);
    check("rst_valid", a_valid, 1'b0);
    check("rst_data", a_data, 32'h0);
    check("rst_idx", a_idx, 6'h0);
    check("rst_last", a_last, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_key_state", dut_a.key_q[0], 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed key 1, consumer always ready; first beat one cycle after start.
    a_ready = 1'b1;
    start_a(128'h1);
    @(negedge clk);
    check("lat_busy", a_busy, 1'b1);
    check("lat_no_valid_yet", a_valid, 1'b0);
    @(negedge clk);
    check("lat_first_valid", a_valid, 1'b1);
    wait_done_a();
    @(negedge clk);
    check("idle_after_done", a_busy, 1'b0);
    @(posedge clk); #1;

    // Back-pressure: the FIFO fills to DEPTH, and state and counter hold.
    a_ready = 1'b0;
    start_a({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_count_full", dut_a.count_q, 3'd4);
    check("bp_ctr_hold", dut_a.ctr_q, 6'd4);
    check("bp_busy", a_busy, 1'b1);
    @(posedge clk); #1 a_ready = 1'b1; gap_chk = 1'b1;
    wait_done_a();
    gap_chk = 1'b0;

    // Abort while full with a toggling consumer, then restart from idx 0.
    start_a({$urandom(), $urandom(), $urandom(), $urandom()});
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1 a_ready = ~a_ready; end
    a_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1 a_abort = 1'b1; a_ready = 1'b1;
    @(posedge clk); #1 a_abort = 1'b0; a_ready = 1'b0; sb_a.delete();
    @(negedge clk);
    check("abort_busy", a_busy, 1'b0);
    check("abort_valid", a_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1 a_ready = 1'b1;
    start_a({$urandom(), $urandom(), $urandom(), $urandom()});
    wait_done_a();

    // A start while busy is ignored; the run keeps its sequence.
    start_a({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (5) @(posedge clk);
    #1 a_key = ~a_key; a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    wait_done_a();

    // A start coincident with abort is ignored while idle.
    a_key = 128'h1234; a_start = 1'b1; a_abort = 1'b1;
    @(posedge clk); #1 a_start = 1'b0; a_abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("start_abort_busy", a_busy, 1'b0);
      check("start_abort_valid", a_valid, 1'b0);
    end
    @(posedge clk); #1;

    // Reset pulse mid-run at beat 5.
    start_a({$urandom(), $urandom(), $urandom(), $urandom()});
    n = 0;
    do begin @(negedge clk); n++; end while (!(a_valid && a_idx == 6'd5) && n < 50);
    check("rst_mid_reached_beat5", a_idx, 6'd5);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", a_busy, 1'b0);
    check("rst_mid_valid", a_valid, 1'b0);
    check("rst_mid_data", a_data, 32'h0);
    check("rst_mid_done", a_done, 1'b0);
    @(posedge clk); #1 rst = 1'b0; sb_a.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_busy", a_busy, 1'b0);
      check("post_rst_valid", a_valid, 1'b0);
    end
    @(posedge clk); #1;

    // LANES=4 directed vector, then a random key.
    b_ready = 1'b1;
    start_b({32'h80008000, 32'h00010000, 32'h0, 32'h00000001});
    wait_done_b();
    start_b({$urandom(), $urandom(), $urandom(), $urandom()});
    wait_done_b();

    // ROUNDS == LANES: the only beat goes straight to DRAIN.
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    c_ready = 1'b1; c_key = key; c_start = 1'b1;
    @(posedge clk); #1 c_start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!c_valid && n < 10);
    check("c_valid", c_valid, 1'b1);
    check("c_data", c_data, key[63:0]);
    check("c_idx", c_idx, 6'd0);
    check("c_last", c_last, 1'b1);
    check("c_state_drain", dut_c.state_q, 2'd2);
    @(negedge clk);
    check("c_valid_after_pop", c_valid, 1'b0);
    check("c_done", c_done, 1'b1);
    @(negedge clk);
    check("c_done_single", c_done, 1'b0);
    check("c_idle", c_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gift_keysched_engine.md
GIFT_KEYSCHED_ENGINE -- requirements
Module: gift_keysched_engine

Parameters
REQ-001 SHALL provide ROUNDS, default 40: number of round keys emitted per run; legal range 1..63; must be a multiple of LANES.
REQ-002 SHALL provide LANES, default 1: round keys produced per cycle; legal values 1, 2, 4.
REQ-003 SHALL provide DEPTH, default 4: output FIFO entries; legal values are powers of 2 with DEPTH >= 2.

Interface
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 key_in  in  128  master key; K0=[31:0], K1=[63:32], K2=[95:64], K3=[127:96]; sampled only when start is accepted.
REQ-007 start  in  1  one-cycle run request.
REQ-008 abort  in  1  cancels the run and flushes the FIFO.
REQ-009 busy  out  1  high whenever state != IDLE.
REQ-010 rk_valid  out  1  FIFO head valid.
REQ-011 rk_ready  in  1  consumer accepts the head.
REQ-012 rk_data  out  32*LANES  round keys; lane j = bits [32j+31:32j].
REQ-013 rk_idx  out  6  round index of lane 0.
REQ-014 rk_last  out  1  head beat is the final beat of the run.
REQ-015 done  out  1  one-cycle pulse when the run completes.

Function
REQ-016 KU(W) SHALL equal {ror16(W[31:16],2), ror16(W[15:0],12)}; ror16 is a rotate right within a 16-bit half.
REQ-017 Key state SHALL be the four words K0..K3, and one step SHALL map (K0,K1,K2,K3) to (K1,K2,K3,KU(K0)).
REQ-018 Round key RK_r SHALL be word K0 of the state after r steps from the loaded key.
- Per pushed beat, lane j carries RK_(r+j), which equals the current Kj.
- The state then advances LANES steps in that cycle.
- LANES=4: each Kj becomes KU(Kj).
REQ-019 FSM states SHALL be IDLE, RUN and DRAIN.
- IDLE -> RUN on start: load key, clear round counter.
- RUN -> DRAIN on the edge where the beat with counter+LANES == ROUNDS is pushed.
- DRAIN -> IDLE when the FIFO is empty; done is pulsed that cycle.
REQ-020 A start that arrives while busy SHALL be ignored.
REQ-021 In RUN, a beat SHALL be pushed on every cycle that the FIFO can accept it.
- The FIFO can accept when count < DEPTH, or when full and a pop occurs in the same cycle.
- When no beat can be pushed, the state and counter SHALL hold.
REQ-022 A pop SHALL occur when rk_valid && rk_ready.
- Simultaneous push and pop SHALL leave the count unchanged.
- Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 Latency: with start sampled at edge t and rk_ready high, the first rk_valid SHALL be visible after edge t+1, and one beat SHALL be emitted per cycle thereafter.
REQ-024 rk_idx SHALL count 0, LANES, 2*LANES, ...; rk_last SHALL be set only on the beat whose rk_idx equals ROUNDS-LANES.
REQ-025 rk_data, rk_idx and rk_last SHALL be held stable while rk_valid && !rk_ready.
REQ-026 abort SHALL take priority over start and over all other transitions.
- Next state is IDLE; FIFO and counter are cleared.
- done is not pulsed.
- A start in the same cycle as abort SHALL be ignored.
REQ-027 If ROUNDS == LANES, the first push SHALL transition RUN -> DRAIN directly.

Reset
REQ-028 While rst is high, the FSM SHALL be in IDLE, pointers and count SHALL be 0, key state SHALL be 0, and all outputs (busy, rk_valid, rk_data, rk_idx, rk_last, done) SHALL be 0.
REQ-029 rst SHALL override abort and start.
REQ-030 rst asserted mid-run SHALL discard all FIFO contents, and no beat SHALL appear after rst is released.

Verification
REQ-031 LANES=1, ROUNDS=40, key_in=0x...00000001, rk_ready=1 -> beats: idx0=0x00000001, idx1..3=0, idx4=0x00000010, idx8=0x00000100; rk_last at idx39; done one cycle after the last pop.
REQ-032 LANES=4, ROUNDS=8, key_in = {K3..K0} = {0x80008000, 0x00010000, 0, 0x00000001} -> beat0 = {0x80008000, 0x00010000, 0, 0x1}; beat1 = {0x20000008, 0x40000000, 0, 0x10} with rk_last=1.
REQ-033 DEPTH=4, rk_ready=0 for 10 cycles -> 4 beats stored, state and counter hold; then rk_ready=1 -> beats in order with no gap or duplicate.
REQ-034 abort while full in RUN, with rk_ready toggling -> next cycle busy=0, rk_valid=0, no done; a new start yields idx0 again.
REQ-035 start while busy, and start on the same cycle as abort -> both ignored; the current run's beat sequence is unchanged (first case) or no run starts (second case).
REQ-036 rst pulse at beat 5 -> all outputs 0 the next cycle; remain IDLE until the next start.
